// File: rtl/smvm_pkg.sv
// Shared types and default constants for the streaming sparse matrix-vector multiplier.
package smvm_pkg;

  localparam int DW_DEF        = 8;
  localparam int CW_DEF        = 7;
  localparam int OUT_DEPTH_DEF = 8;

  // Slots a MAT beat must find free before it is accepted: one per pipeline stage plus itself.
  localparam int MAT_ROOM_MIN  = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR_C,
    VEC_IN,
    MAT_IN,
    DRAIN
  } state_t;

endpackage

// File: rtl/smvm_stream_if.sv
// Input beat stream and result stream of smvm_stream, grouped with producer/consumer views.
interface smvm_stream_if
  import smvm_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int ACC_W = 2 * DW + CW
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [DW-1:0]    val_in;
  logic        [CW-1:0]    col_in;
  logic                    row_end_in;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] data_out;
  logic        [CW-1:0]    out_row;

  modport master (
    output in_valid, val_in, col_in, row_end_in, out_ready,
    input  in_ready, out_valid, data_out, out_row
  );

  modport slave (
    input  in_valid, val_in, col_in, row_end_in, out_ready,
    output in_ready, out_valid, data_out, out_row
  );

endinterface

// File: rtl/smvm_out_fifo.sv
// Result queue: synchronous FIFO with show-ahead head word and occupancy count.
module smvm_out_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int              PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; pointers and count define validity, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/smvm_stream.sv
// Streaming sparse matrix-vector multiply: header, dense vector, then CSR-like nonzero beats;
// one signed dot-product per row through a 3-stage datapath into a result FIFO.
module smvm_stream
  import smvm_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int CW        = CW_DEF,
  parameter int ACC_W     = 2 * DW + CW,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  smvm_stream_if.slave   bus,
  output logic           done,
  output logic           err
);

  localparam int          FW    = ACC_W + CW;
  localparam int          FCW   = $clog2(OUT_DEPTH + 1);
  localparam logic [CW:0] ONE   = (CW + 1)'(1);

  state_t state, state_nxt;

  logic [CW:0] rows, cols, vec_cnt, mat_rows;
  logic        in_ready, in_fire, col_oob, last_row, mat_room;
  int          used_slots;

  logic signed [DW-1:0]    vec_mem [2**CW];
  logic                    s1_valid, s1_end, s1_oob;
  logic signed [DW-1:0]    s1_val, s1_vec;
  logic signed [2*DW-1:0]  prod_full;
  logic                    s2_valid, s2_end;
  logic signed [ACC_W-1:0] s2_prod, acc, acc_sum, s3_data;
  logic                    s3_valid;
  logic        [CW-1:0]    acc_row, s3_row;

  logic [FW-1:0]  fifo_head;
  logic           fifo_empty, fifo_pop;
  logic [FCW-1:0] fifo_count;

  assign in_fire  = bus.in_valid & in_ready;
  assign col_oob  = ({1'b0, bus.col_in} >= cols);
  assign last_row = (mat_rows == rows - ONE);

  // Rows already committed to the FIFO: queued results plus row_end beats still in the pipeline.
  assign used_slots = int'(fifo_count) + int'(s1_valid & s1_end) + int'(s2_valid & s2_end)
                    + int'(s3_valid);
  assign mat_room   = (OUT_DEPTH - used_slots) >= MAT_ROOM_MIN;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = HDR_C;
      end
      HDR_C: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = VEC_IN;
      end
      VEC_IN: begin
        in_ready = 1'b1;
        if (bus.in_valid && vec_cnt == cols - ONE) state_nxt = MAT_IN;
      end
      MAT_IN: begin
        in_ready = mat_room;
        if (bus.in_valid && mat_room && bus.row_end_in && last_row) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!(s1_valid || s2_valid || s3_valid) && fifo_empty) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Header, vector and row bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows     <= '0;
      cols     <= '0;
      vec_cnt  <= '0;
      mat_rows <= '0;
      err      <= 1'b0;
    end else if (in_fire) begin
      case (state)
        IDLE: begin
          rows     <= {1'b0, bus.col_in} + ONE;
          mat_rows <= '0;
          err      <= 1'b0;
        end
        HDR_C: begin
          cols    <= {1'b0, bus.col_in} + ONE;
          vec_cnt <= '0;
        end
        VEC_IN: vec_cnt <= vec_cnt + ONE;
        MAT_IN: begin
          if (col_oob)        err      <= 1'b1;
          if (bus.row_end_in) mat_rows <= mat_rows + ONE;
        end
        default: ;
      endcase
    end
  end

  // Vector RAM: written during VEC_IN, read as pipeline stage 1.
  always_ff @(posedge clk) begin
    if (in_fire && state == VEC_IN) vec_mem[vec_cnt[CW-1:0]] <= bus.val_in;
    s1_vec <= vec_mem[bus.col_in];
  end

  assign prod_full = (2*DW)'(s1_val) * (2*DW)'(s1_vec);
  assign acc_sum   = acc + s2_prod;

  // Stage 1 vector read, stage 2 multiply, stage 3 accumulate and stage the FIFO push.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_end   <= 1'b0;
      s1_oob   <= 1'b0;
      s1_val   <= '0;
      s2_valid <= 1'b0;
      s2_end   <= 1'b0;
      s2_prod  <= '0;
      s3_valid <= 1'b0;
      s3_data  <= '0;
      s3_row   <= '0;
      acc      <= '0;
      acc_row  <= '0;
    end else begin
      s1_valid <= in_fire && state == MAT_IN;
      s1_end   <= bus.row_end_in;
      s1_oob   <= col_oob;
      s1_val   <= bus.val_in;

      s2_valid <= s1_valid;
      s2_end   <= s1_valid & s1_end;
      s2_prod  <= s1_oob ? '0 : ACC_W'(prod_full);

      s3_valid <= s2_valid & s2_end;
      if (s2_valid) begin
        if (s2_end) begin
          s3_data <= acc_sum;
          s3_row  <= acc_row;
          acc     <= '0;
          acc_row <= acc_row + CW'(1);
        end else begin
          acc <= acc_sum;
        end
      end
      if (in_fire && state == IDLE) acc_row <= '0;
    end
  end

  smvm_out_fifo #(
    .W     (FW),
    .DEPTH (OUT_DEPTH),
    .CNT_W (FCW)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s3_valid),
    .push_data ({s3_row, s3_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign fifo_pop      = bus.out_valid & bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ~fifo_empty;
  assign bus.data_out  = fifo_head[ACC_W-1:0];
  assign bus.out_row   = fifo_head[FW-1:ACC_W];

endmodule
